// File: rtl/branch_pkg.sv
// branch_pkg: FSM encoding, fetch PC step and prediction-entry layout shared by branch_resolve
package branch_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PEND    = 2'd1,
        S_RECOVER = 2'd2
    } br_state_t;

    localparam int PC_INCR = 4;

    // Entry is packed {taken, pc, target} with target in the low XLEN bits
    function automatic int ent_w(input int xlen);
        return 2 * xlen + 1;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pred_fifo.sv
// pred_fifo: DEPTH-entry prediction queue; pointers carry a phase bit to tell full from empty
module pred_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  logic [W-1:0]             i_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [W-1:0]             o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (i_clear) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_clear) r_mem[r_wr[AW-1:0]] <= i_data;
    end

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_head  = r_mem[r_rd[AW-1:0]];
    assign o_count = r_wr - r_rd;

endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: tracks outstanding branch predictions, checks them against execute-side
// resolutions, trains the predictor and raises a one-cycle flush with the corrected fetch PC
module branch_resolve
    import branch_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int DEPTH          = 4,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pred_valid,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_pc,
    input  logic [XLEN-1:0] pred_target,
    input  logic            res_valid,
    input  logic            res_taken,
    input  logic [XLEN-1:0] res_target,
    output logic            upd_br_x,
    output logic            upd_br_true,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc,
    output logic            fetch_stall,
    output logic [15:0]     branch_count,
    output logic [15:0]     mispredict_count,
    output logic            err
);

    localparam int EW = ent_w(XLEN);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(RECOVER_CYCLES + 1);

    br_state_t       r_state;
    br_state_t       w_state_nxt;
    logic [RW-1:0]   r_rcnt;
    logic [RW-1:0]   w_rcnt_nxt;
    logic            r_upd_x;
    logic            r_upd_true;
    logic            r_flush;
    logic [XLEN-1:0] r_redirect;
    logic [15:0]     r_bcnt;
    logic [15:0]     r_mcnt;
    logic            r_err;

    logic            w_full;
    logic            w_empty;
    logic [EW-1:0]   w_head;
    logic [AW:0]     w_count;
    logic            w_h_taken;
    logic [XLEN-1:0] w_h_pc;
    logic [XLEN-1:0] w_h_tgt;
    logic            w_pop;
    logic            w_mis;
    logic            w_push;
    logic            w_err;

    pred_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_mis),
        .i_data  ({pred_taken, pred_pc, pred_target}),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign w_h_taken = w_head[EW-1];
    assign w_h_pc    = w_head[EW-2 -: XLEN];
    assign w_h_tgt   = w_head[XLEN-1:0];

    assign w_pop  = res_valid && !w_empty;
    assign w_mis  = w_pop && ((res_taken != w_h_taken) || (res_taken && (res_target != w_h_tgt)));
    // Flush wins over a same-cycle push; a full queue only takes a push alongside a pop
    assign w_push = pred_valid && (r_state != S_RECOVER) && !w_mis && (!w_full || w_pop);
    assign w_err  = (res_valid && w_empty) ||
                    (pred_valid && (r_state != S_RECOVER) && w_full && !w_pop);

    always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        if (w_mis) begin
            w_state_nxt = S_RECOVER;
            w_rcnt_nxt  = RW'(RECOVER_CYCLES - 1);
        end else begin
            case (r_state)
                S_IDLE:    w_state_nxt = w_push ? S_PEND : S_IDLE;
                S_PEND:    w_state_nxt = (w_pop && !w_push && (w_count == (AW+1)'(1))) ? S_IDLE : S_PEND;
                S_RECOVER: begin
                    w_state_nxt = (r_rcnt == '0) ? S_IDLE : S_RECOVER;
                    w_rcnt_nxt  = (r_rcnt == '0) ? r_rcnt : r_rcnt - 1'b1;
                end
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rcnt     <= '0;
            r_upd_x    <= 1'b0;
            r_upd_true <= 1'b0;
            r_flush    <= 1'b0;
            r_redirect <= '0;
            r_bcnt     <= '0;
            r_mcnt     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rcnt     <= w_rcnt_nxt;
            r_upd_x    <= w_pop;
            r_upd_true <= w_pop && res_taken;
            r_flush    <= w_mis;
            if (w_mis) r_redirect <= res_taken ? res_target : w_h_pc + XLEN'(PC_INCR);
            if (w_pop) r_bcnt <= sat_inc(r_bcnt);
            if (w_mis) r_mcnt <= sat_inc(r_mcnt);
            if (w_err) r_err <= 1'b1;
        end
    end

    assign upd_br_x         = r_upd_x;
    assign upd_br_true      = r_upd_true;
    assign flush            = r_flush;
    assign redirect_pc      = r_redirect;
    assign fetch_stall      = w_full;
    assign branch_count     = r_bcnt;
    assign mispredict_count = r_mcnt;
    assign err              = r_err;

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: scoreboard bench; a reference model predicts every cycle's outputs
module tb_branch_resolve;
    import branch_pkg::*;

    localparam int DEPTH = 4;
    localparam int RC    = 2;

    typedef struct {
        logic        t;
        logic [31:0] pc;
        logic [31:0] tgt;
    } ent_t;

    typedef struct {
        logic        upd;
        logic        tru;
        logic        fl;
        logic [31:0] rd;
        logic [15:0] bc;
        logic [15:0] mc;
        logic        er;
        logic        st;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pred_valid = 1'b0, pred_taken = 1'b0;
    logic [31:0] pred_pc = '0, pred_target = '0;
    logic        res_valid = 1'b0, res_taken = 1'b0;
    logic [31:0] res_target = '0;
    logic        upd_br_x, upd_br_true, flush, fetch_stall, err;
    logic [31:0] redirect_pc;
    logic [15:0] branch_count, mispredict_count;

    int n_checks = 0;
    int n_errors = 0;

    ent_t        mq[$];
    exp_t        sb[$];
    int          mrec = 0;
    logic [31:0] m_rd = '0;
    logic [15:0] m_bc = '0, m_mc = '0;
    logic        m_err = 1'b0;

    branch_resolve #(.XLEN(32), .DEPTH(DEPTH), .RECOVER_CYCLES(RC)) dut (
        .clk              (clk),
        .rst              (rst),
        .pred_valid       (pred_valid),
        .pred_taken       (pred_taken),
        .pred_pc          (pred_pc),
        .pred_target      (pred_target),
        .res_valid        (res_valid),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .upd_br_x         (upd_br_x),
        .upd_br_true      (upd_br_true),
        .flush            (flush),
        .redirect_pc      (redirect_pc),
        .fetch_stall      (fetch_stall),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count),
        .err              (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
    endfunction

    task automatic cmp_pending();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("upd_br_x", upd_br_x, e.upd);
            check("upd_br_true", upd_br_true, e.tru);
            check("flush", flush, e.fl);
            check("redirect_pc", redirect_pc, e.rd);
            check("branch_count", branch_count, e.bc);
            check("mispredict_count", mispredict_count, e.mc);
            check("err", err, e.er);
            check("fetch_stall", fetch_stall, e.st);
        end
    endtask

    task automatic step(input logic pv, input logic pt, input logic [31:0] ppc, input logic [31:0] ptg,
                        input logic rv, input logic rt, input logic [31:0] rtg);
        exp_t e;
        ent_t h;
        logic pop, mis, push;
        @(negedge clk);
        cmp_pending();
        pred_valid = pv; pred_taken = pt; pred_pc = ppc; pred_target = ptg;
        res_valid = rv; res_taken = rt; res_target = rtg;
        h = '{1'b0, 32'h0, 32'h0};
        pop = rv && (mq.size() > 0);
        if (pop) h = mq[0];
        mis = pop && ((rt != h.t) || (rt && (rtg != h.tgt)));
        push = pv && (mrec == 0) && !mis && ((mq.size() < DEPTH) || pop);
        if ((rv && mq.size() == 0) || (pv && mrec == 0 && mq.size() == DEPTH && !pop)) m_err = 1'b1;
        if (pop) m_bc = sat16(m_bc);
        if (mis) begin
            m_mc = sat16(m_mc);
            m_rd = rt ? rtg : h.pc + 32'd4;
        end
        if (mis) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back('{pt, ppc, ptg});
        end
        mrec = mis ? RC : ((mrec > 0) ? mrec - 1 : 0);
        e = '{pop, pop && rt, mis, m_rd, m_bc, m_mc, m_err, mq.size() == DEPTH};
        sb.push_back(e);
    endtask

    task automatic push(input logic t, input logic [31:0] pc, input logic [31:0] tg);
        step(1'b1, t, pc, tg, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic resolve(input logic t, input logic [31:0] tg);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, t, tg);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        cmp_pending();
        pred_valid = 1'b0; res_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_upd_br_x", upd_br_x, 1'b0);
        check("rst_upd_br_true", upd_br_true, 1'b0);
        check("rst_flush", flush, 1'b0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        check("rst_branch_count", branch_count, 16'h0);
        check("rst_mispredict_count", mispredict_count, 16'h0);
        check("rst_err", err, 1'b0);
        check("rst_fetch_stall", fetch_stall, 1'b0);
        check("rst_fsm", dut.r_state, S_IDLE);
        sb.delete(); mq.delete();
        mrec = 0; m_rd = '0; m_bc = '0; m_mc = '0; m_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic pv, pt, rv, rt;
        logic [31:0] ppc, ptg, rtg;

        do_reset();

        // Correct taken prediction, then taken branch mispredicted as not-taken
        push(1'b1, 32'h100, 32'h200);
        resolve(1'b1, 32'h200);
        idle(1);
        push(1'b0, 32'h100, 32'h0);
        resolve(1'b1, 32'h300);
        idle(3);

        // Taken head resolves not-taken; younger entries and recovery-window pushes are dropped
        push(1'b1, 32'h40, 32'h80);
        push(1'b0, 32'h50, 32'h0);
        push(1'b1, 32'h60, 32'h90);
        step(1'b1, 1'b0, 32'h70, 32'h0, 1'b1, 1'b0, 32'h0);
        push(1'b0, 32'h74, 32'h0);
        push(1'b0, 32'h78, 32'h0);
        push(1'b1, 32'h10, 32'h20);
        resolve(1'b1, 32'h20);
        idle(1);

        // Fill the queue, push with pop while full, then push while full without pop
        for (int i = 0; i < DEPTH; i++) push(1'b1, 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16));
        step(1'b1, 1'b1, 32'h1100, 32'h2100, 1'b1, 1'b1, 32'h2000);
        push(1'b1, 32'h1200, 32'h2200);
        resolve(1'b1, 32'h2010);
        resolve(1'b1, 32'h2020);
        resolve(1'b1, 32'h2030);
        resolve(1'b1, 32'h2100);
        idle(1);

        // Resolution with nothing outstanding
        do_reset();
        resolve(1'b1, 32'h10);
        idle(2);

        // Mixed traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            pv  = 1'($urandom_range(0, 1));
            pt  = 1'($urandom_range(0, 1));
            ppc = 32'($urandom_range(0, 15)) << 4;
            ptg = $urandom_range(0, 1) ? 32'h200 : 32'h300;
            rv  = 1'($urandom_range(0, 1));
            rt  = 1'($urandom_range(0, 1));
            rtg = $urandom_range(0, 1) ? 32'h200 : 32'h300;
            if (rv && mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                rt  = mq[0].t;
                rtg = mq[0].t ? mq[0].tgt : rtg;
            end
            step(pv, pt, ppc, ptg, rv, rt, rtg);
        end
        idle(3);

        // Mispredict counter saturation from a preloaded value near the top
        do_reset();
        idle(1);
        force dut.r_mcnt = 16'hFFFD;
        m_mc = 16'hFFFD;
        sb[sb.size() - 1].mc = 16'hFFFD;
        @(posedge clk);
        #1;
        release dut.r_mcnt;
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 32'h300 + 32'(i * 4), 32'h0);
            resolve(1'b1, 32'h500);
            idle(2);
        end
        idle(1);

        // Reset with entries outstanding, then reset in the middle of recovery
        do_reset();
        push(1'b1, 32'h40, 32'h80);
        push(1'b1, 32'h44, 32'h88);
        push(1'b1, 32'h48, 32'h8C);
        do_reset();
        resolve(1'b1, 32'h80);
        idle(1);
        do_reset();
        push(1'b1, 32'h40, 32'h80);
        push(1'b1, 32'h44, 32'h88);
        push(1'b1, 32'h48, 32'h8C);
        resolve(1'b0, 32'h0);
        idle(1);
        do_reset();
        idle(4);
        check("post_rst_fsm", dut.r_state, S_IDLE);
        push(1'b1, 32'h900, 32'hA00);
        resolve(1'b1, 32'hA00);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC/target width.
REQ-002 SHALL have parameter DEPTH, default 4, number of outstanding predictions tracked (power of 2).
REQ-003 SHALL have parameter RECOVER_CYCLES, default 2, cycles pushes are dropped after a flush (>=1).
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports pred_valid in 1, pred_taken in 1, pred_pc in XLEN, pred_target in XLEN: fetch-side prediction push.
REQ-007 SHALL have ports res_valid in 1, res_taken in 1, res_target in XLEN: execute-side branch resolution.
REQ-008 SHALL have ports upd_br_x out 1, upd_br_true out 1: predictor training (branch executed, actual outcome).
REQ-009 SHALL have ports flush out 1, redirect_pc out XLEN: one-cycle mispredict recovery pulse and correct fetch PC.
REQ-010 SHALL have port fetch_stall out 1: asserted while the tracking queue is full.
REQ-011 SHALL have ports branch_count out 16, mispredict_count out 16, err out 1: saturating statistics and sticky protocol error.

Function
REQ-012 SHALL hold pushed predictions {pred_taken, pred_pc, pred_target} in a DEPTH-entry FIFO, oldest resolved first.
REQ-013 SHALL pop the head on res_valid and compare: mispredict = (res_taken != head.taken) OR (res_taken AND res_target != head.target).
REQ-014 SHALL drive all outputs from registers; upd_*, flush, redirect_pc valid exactly 1 cycle after the res_valid cycle.
REQ-015 SHALL pulse upd_br_x=1 for one cycle per resolved branch with upd_br_true=res_taken; both 0 otherwise.
REQ-016 SHALL on mispredict pulse flush=1 for one cycle, redirect_pc = res_target if res_taken else head.pc+4 (mod 2^XLEN).
REQ-017 SHALL hold redirect_pc at its last value when flush=0.
REQ-018 SHALL on mispredict discard all younger FIFO entries (wrong path) in the same edge as the pop.
REQ-019 SHALL implement FSM IDLE (queue empty), PEND (queue non-empty), RECOVER; IDLE->PEND on accepted push; PEND->IDLE when last entry popped without mispredict; any->RECOVER on mispredict; RECOVER->IDLE after RECOVER_CYCLES cycles.
REQ-020 SHALL ignore pred_valid while in RECOVER and in the mispredict cycle itself (flush wins over push).
REQ-021 SHALL accept a simultaneous push and correct-resolution pop in one cycle, occupancy unchanged, including when full.
REQ-022 SHALL assert fetch_stall combinationally from occupancy==DEPTH; a push while full without a pop SHALL be dropped and set err.
REQ-023 SHALL set err on res_valid with empty queue, producing no upd_*/flush pulse and no count change.
REQ-024 SHALL increment branch_count per resolved branch and mispredict_count per mispredict, each saturating at 0xFFFF.
REQ-025 SHALL wrap FIFO pointers modulo DEPTH using an extra phase bit for full/empty.

Reset
REQ-026 SHALL on rst clear queue, FSM to IDLE, upd_br_x=0, upd_br_true=0, flush=0, redirect_pc=0, counts=0, err=0, immediately and independent of clk.
REQ-027 SHALL, on rst asserted mid-operation or mid-RECOVER, discard all outstanding entries; no pulse emitted after deassertion.

Structure
REQ-028 SHALL place FSM state encoding (IDLE/PEND/RECOVER), PC_INCR=4 and the prediction-entry record layout in shared package branch_pkg.
REQ-029 SHALL implement the queue as sub-module pred_fifo (push, pop, clear, full, empty, head) instantiated once.

Verification
REQ-030 Push (taken, pc=0x100, tgt=0x200); resolve taken tgt=0x200 -> next cycle upd_br_x=1, upd_br_true=1, flush=0, branch_count=1.
REQ-031 Push (not-taken, pc=0x100); resolve taken tgt=0x300 -> flush=1, redirect_pc=0x300, mispredict_count=1, queue empty.
REQ-032 Push (taken, pc=0x40, tgt=0x80) plus 2 younger; resolve not-taken -> flush, redirect_pc=0x44, younger entries discarded, pushes dropped for 2 cycles.
REQ-033 Push 4 entries -> fetch_stall=1; 5th push with pop same cycle accepted; 5th push without pop -> dropped, err=1.
REQ-034 res_valid with empty queue -> err=1, no upd_*/flush; 65536+ mispredicts -> mispredict_count holds 0xFFFF.
REQ-035 Assert rst during RECOVER with 3 entries queued -> all outputs 0 immediately, FSM IDLE, no pulse after release.
